// File: rtl/mam_mem_arbiter.sv
// Round-robin arbiter sharing one MAM memory port between two masters.
// The grant is held for a whole transaction: the request handshake and every data beat.
module mam_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_req_valid,
    output logic                      m0_req_ready,
    input  logic                      m0_req_rw,
    input  logic [ADDR_WIDTH-1:0]     m0_req_addr,
    input  logic                      m0_req_burst,
    input  logic [13:0]               m0_req_beats,
    input  logic                      m0_write_valid,
    input  logic [DATA_WIDTH-1:0]     m0_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m0_write_strb,
    output logic                      m0_write_ready,
    output logic                      m0_read_valid,
    output logic [DATA_WIDTH-1:0]     m0_read_data,
    input  logic                      m0_read_ready,

    input  logic                      m1_req_valid,
    output logic                      m1_req_ready,
    input  logic                      m1_req_rw,
    input  logic [ADDR_WIDTH-1:0]     m1_req_addr,
    input  logic                      m1_req_burst,
    input  logic [13:0]               m1_req_beats,
    input  logic                      m1_write_valid,
    input  logic [DATA_WIDTH-1:0]     m1_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m1_write_strb,
    output logic                      m1_write_ready,
    output logic                      m1_read_valid,
    output logic [DATA_WIDTH-1:0]     m1_read_data,
    input  logic                      m1_read_ready,

    output logic                      req_valid,
    output logic                      req_rw,
    output logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      req_burst,
    output logic [13:0]               req_beats,
    input  logic                      req_ready,
    output logic                      write_valid,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH/8-1:0]   write_strb,
    input  logic                      write_ready,
    input  logic                      read_valid,
    input  logic [DATA_WIDTH-1:0]     read_data,
    output logic                      read_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_gnt;   // 0 = m0, 1 = m1
    logic        r_prio;
    logic        r_rw;
    logic [13:0] r_cnt;

    logic                    w_in_req;
    logic                    w_in_wr;
    logic                    w_in_rd;
    logic                    w_sel_req_valid;
    logic                    w_sel_req_rw;
    logic [ADDR_WIDTH-1:0]   w_sel_req_addr;
    logic                    w_sel_req_burst;
    logic [13:0]             w_sel_req_beats;
    logic                    w_sel_write_valid;
    logic [DATA_WIDTH-1:0]   w_sel_write_data;
    logic [DATA_WIDTH/8-1:0] w_sel_write_strb;
    logic                    w_sel_read_ready;
    logic                    w_req_hs;
    logic                    w_beat_hs;
    logic [13:0]             w_beats;

    assign w_in_req = (r_state == REQ);
    assign w_in_wr  = (r_state == DATA) &&  r_rw;
    assign w_in_rd  = (r_state == DATA) && !r_rw;

    assign w_sel_req_valid   = r_gnt ? m1_req_valid   : m0_req_valid;
    assign w_sel_req_rw      = r_gnt ? m1_req_rw      : m0_req_rw;
    assign w_sel_req_addr    = r_gnt ? m1_req_addr    : m0_req_addr;
    assign w_sel_req_burst   = r_gnt ? m1_req_burst   : m0_req_burst;
    assign w_sel_req_beats   = r_gnt ? m1_req_beats   : m0_req_beats;
    assign w_sel_write_valid = r_gnt ? m1_write_valid : m0_write_valid;
    assign w_sel_write_data  = r_gnt ? m1_write_data  : m0_write_data;
    assign w_sel_write_strb  = r_gnt ? m1_write_strb  : m0_write_strb;
    assign w_sel_read_ready  = r_gnt ? m1_read_ready  : m0_read_ready;

    // Memory side is forced to zero outside the phase that owns each channel.
    assign req_valid   = w_in_req & w_sel_req_valid;
    assign req_rw      = w_in_req & w_sel_req_rw;
    assign req_addr    = w_in_req ? w_sel_req_addr  : '0;
    assign req_burst   = w_in_req & w_sel_req_burst;
    assign req_beats   = w_in_req ? w_sel_req_beats : '0;
    assign write_valid = w_in_wr & w_sel_write_valid;
    assign write_data  = w_in_wr ? w_sel_write_data : '0;
    assign write_strb  = w_in_wr ? w_sel_write_strb : '0;
    assign read_ready  = w_in_rd & w_sel_read_ready;

    assign m0_req_ready   = w_in_req & ~r_gnt & req_ready;
    assign m1_req_ready   = w_in_req &  r_gnt & req_ready;
    assign m0_write_ready = w_in_wr  & ~r_gnt & write_ready;
    assign m1_write_ready = w_in_wr  &  r_gnt & write_ready;
    assign m0_read_valid  = w_in_rd  & ~r_gnt & read_valid;
    assign m1_read_valid  = w_in_rd  &  r_gnt & read_valid;
    assign m0_read_data   = (w_in_rd & ~r_gnt) ? read_data : '0;
    assign m1_read_data   = (w_in_rd &  r_gnt) ? read_data : '0;

    assign w_req_hs  = req_valid & req_ready;
    assign w_beat_hs = (write_valid & write_ready) | (read_valid & read_ready);
    // A zero-length burst still moves one word, so the counter never starts at 0.
    assign w_beats   = (req_burst && (req_beats != 14'd0)) ? req_beats : 14'd1;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_prio  <= 1'b0;
            r_rw    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_req_valid || m1_req_valid) begin
                        r_gnt   <= (m0_req_valid && m1_req_valid) ? r_prio : m1_req_valid;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_req_hs) begin
                        r_rw    <= req_rw;
                        r_cnt   <= w_beats;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat_hs) begin
                        if (r_cnt == 14'd1) begin
                            r_cnt   <= '0;
                            r_prio  <= ~r_gnt;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 14'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Directed bench for mam_mem_arbiter: a per-cycle vector table for the main
// transaction shapes, then hand-written sequences for stall, alternation and reset.
module tb_mam_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m0_req_ready, m0_req_rw, m0_req_burst;
    logic [AW-1:0] m0_req_addr;
    logic [13:0]   m0_req_beats;
    logic          m0_write_valid, m0_write_ready, m0_read_valid, m0_read_ready;
    logic [DW-1:0] m0_write_data, m0_read_data;
    logic [SW-1:0] m0_write_strb;
    logic          m1_req_valid, m1_req_ready, m1_req_rw, m1_req_burst;
    logic [AW-1:0] m1_req_addr;
    logic [13:0]   m1_req_beats;
    logic          m1_write_valid, m1_write_ready, m1_read_valid, m1_read_ready;
    logic [DW-1:0] m1_write_data, m1_read_data;
    logic [SW-1:0] m1_write_strb;
    logic          req_valid, req_rw, req_burst, req_ready;
    logic [AW-1:0] req_addr;
    logic [13:0]   req_beats;
    logic          write_valid, write_ready, read_valid, read_ready;
    logic [DW-1:0] write_data, read_data;
    logic [SW-1:0] write_strb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mam_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_rw(m0_req_rw),
        .m0_req_addr(m0_req_addr), .m0_req_burst(m0_req_burst), .m0_req_beats(m0_req_beats),
        .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
        .m0_write_strb(m0_write_strb), .m0_write_ready(m0_write_ready),
        .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ready(m0_read_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_rw(m1_req_rw),
        .m1_req_addr(m1_req_addr), .m1_req_burst(m1_req_burst), .m1_req_beats(m1_req_beats),
        .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
        .m1_write_strb(m1_write_strb), .m1_write_ready(m1_write_ready),
        .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ready(m1_read_ready),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_burst(req_burst),
        .req_beats(req_beats), .req_ready(req_ready),
        .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
        .write_ready(write_ready),
        .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready)
    );

    // Memory-side write log: every accepted write beat in order.
    logic [DW-1:0] wr_log[$];
    always @(posedge clk) begin
        if (write_valid && write_ready) wr_log.push_back(write_data);
    end

    typedef struct {
        logic          rw;
        logic          burst;
        logic [13:0]   beats;
        logic [AW-1:0] addr;
    } cfg_t;

    typedef struct {
        string         nm;
        int            c0, c1;
        logic [1:0]    rv, wv, rr;
        logic [DW-1:0] wd0, wd1, rd;
        logic          rq_rdy, wr_rdy, rd_vld;
        logic          e_reqv, e_wv, e_rrdy;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_reqrdy, e_wrdy, e_rv;
        logic [DW-1:0] e_wd, e_rd0, e_rd1;
    } vec_t;

    cfg_t cfgs[6];
    vec_t tbl[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input int c0, input int c1,
                           input logic [1:0] rv, input logic [1:0] wv,
                           input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                           input logic rq_rdy, input logic wr_rdy, input logic [1:0] rr,
                           input logic rd_vld, input logic [DW-1:0] rd,
                           input logic e_reqv, input logic [AW-1:0] e_addr,
                           input logic [1:0] e_reqrdy, input logic e_wv, input logic [DW-1:0] e_wd,
                           input logic [1:0] e_wrdy, input logic e_rrdy, input logic [1:0] e_rv,
                           input logic [DW-1:0] e_rd0, input logic [DW-1:0] e_rd1);
        vec_t v;
        v.nm = nm; v.c0 = c0; v.c1 = c1; v.rv = rv; v.wv = wv; v.wd0 = wd0; v.wd1 = wd1;
        v.rq_rdy = rq_rdy; v.wr_rdy = wr_rdy; v.rr = rr; v.rd_vld = rd_vld; v.rd = rd;
        v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_reqrdy = e_reqrdy; v.e_wv = e_wv;
        v.e_wd = e_wd; v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_rv = e_rv;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        tbl.push_back(v);
    endtask

    function automatic logic [127:0] all_out();
        return {21'd0, req_valid, req_rw, req_addr, req_burst, req_beats,
                write_valid, write_data, write_strb, read_ready,
                m0_req_ready, m0_write_ready, m0_read_valid, m0_read_data,
                m1_req_ready, m1_write_ready, m1_read_valid, m1_read_data};
    endfunction

    function automatic logic [127:0] log_pack(input int base);
        logic [127:0] p = '0;
        for (int i = base; i < wr_log.size(); i++) p = {p[111:0], wr_log[i]};
        return p;
    endfunction

    initial begin
        int base;
        int bad;

        cfgs[0] = '{1'b1, 1'b0, 14'd0, 32'h0000_0000};
        cfgs[1] = '{1'b1, 1'b1, 14'd3, 32'h0000_1000};
        cfgs[2] = '{1'b1, 1'b1, 14'd3, 32'h0000_2000};
        cfgs[3] = '{1'b0, 1'b1, 14'd4, 32'h0000_3000};
        cfgs[4] = '{1'b1, 1'b1, 14'd0, 32'h0000_4000};
        cfgs[5] = '{1'b0, 1'b0, 14'd9, 32'h0000_5000};

        //        name          c0 c1 rv     wv     wd0      wd1      rq wr  rr     rdv  rd
        //        | reqv  addr          reqrdy wv    wd       wrdy   rrdy rv     rd0    rd1
        // Both masters request together: m0 first, one IDLE gap, then m1.
        add_vec("a_idle",       1, 2, 2'b11, 2'b00, 16'h0,   16'h0,   1'b0, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_req_m0",     1, 2, 2'b11, 2'b00, 16'h0,   16'h0,   1'b1, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b1, 32'h1000,   2'b01, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr1_stall",  1, 2, 2'b10, 2'b01, 16'h1,   16'h0,   1'b1, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h1,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr1",        1, 2, 2'b10, 2'b01, 16'h1,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h1,   2'b01, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr2",        1, 2, 2'b10, 2'b01, 16'h2,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h2,   2'b01, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr3",        1, 2, 2'b10, 2'b01, 16'h3,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h3,   2'b01, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_gap",        1, 2, 2'b10, 2'b00, 16'h0,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_req_m1",     1, 2, 2'b10, 2'b00, 16'h0,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b1, 32'h2000,   2'b10, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr4",        1, 2, 2'b00, 2'b10, 16'h0,   16'h4,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h4,   2'b10, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr5",        1, 2, 2'b00, 2'b10, 16'h0,   16'h5,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h5,   2'b10, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_wr6",        1, 2, 2'b00, 2'b10, 16'h0,   16'h6,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h6,   2'b10, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("a_done",       1, 2, 2'b00, 2'b00, 16'h0,   16'h0,   1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        // m1 burst read of 4 with its read_ready toggling; m0_read_ready must have no effect.
        add_vec("b_idle",       0, 3, 2'b10, 2'b00, 16'h0,   16'h0,   1'b0, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("b_req_wait",   0, 3, 2'b10, 2'b00, 16'h0,   16'h0,   1'b0, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b1, 32'h3000,   2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("b_req",        0, 3, 2'b10, 2'b00, 16'h0,   16'h0,   1'b1, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b1, 32'h3000,   2'b10, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            add_vec($sformatf("b_rd%0d_hold", k), 0, 3, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0,
                    2'b01, 1'b1, 16'h00A0 + 16'(k),
                    1'b0, 32'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0, 2'b10, 16'h0, 16'h00A0 + 16'(k));
            add_vec($sformatf("b_rd%0d", k), 0, 3, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0,
                    2'b10, 1'b1, 16'h00A0 + 16'(k),
                    1'b0, 32'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, 2'b10, 16'h0, 16'h00A0 + 16'(k));
        end
        add_vec("b_stray_rd",   0, 3, 2'b00, 2'b00, 16'h0,   16'h0,   1'b1, 1'b0, 2'b11, 1'b1, 16'h00BB,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        // Burst with beats=0 behaves as a single word.
        add_vec("c_idle",       4, 0, 2'b01, 2'b00, 16'h0,   16'h0,   1'b0, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("c_req",        4, 0, 2'b01, 2'b00, 16'h0,   16'h0,   1'b1, 1'b0, 2'b00, 1'b0, 16'h0,
                1'b1, 32'h4000,   2'b01, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("c_wr",         4, 0, 2'b00, 2'b01, 16'h0BEE, 16'h0,  1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b1, 16'h0BEE, 2'b01, 1'b0, 2'b00, 16'h0, 16'h0);
        add_vec("c_idle_after", 4, 0, 2'b00, 2'b01, 16'h0BEF, 16'h0,  1'b1, 1'b1, 2'b00, 1'b0, 16'h0,
                1'b0, 32'h0,      2'b00, 1'b0, 16'h0,   2'b00, 1'b0, 2'b00, 16'h0, 16'h0);

        // Reset with some inputs active: nothing may leak to the outputs.
        rst = 1'b1;
        {m0_req_valid, m0_req_rw, m0_req_burst, m0_write_valid, m0_read_ready} = 5'b10000;
        {m1_req_valid, m1_req_rw, m1_req_burst, m1_write_valid, m1_read_ready} = '0;
        m0_req_addr = '0; m0_req_beats = '0; m0_write_data = '0; m0_write_strb = 2'b11;
        m1_req_addr = '0; m1_req_beats = '0; m1_write_data = '0; m1_write_strb = 2'b10;
        req_ready = 1'b1; write_ready = 1'b1; read_valid = 1'b1; read_data = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", all_out(), '0);
        rst = 1'b0; m0_req_valid = 1'b0; req_ready = 1'b0; write_ready = 1'b0;
        read_valid = 1'b0; read_data = '0;

        base = wr_log.size();
        foreach (tbl[k]) begin
            @(negedge clk);
            {m0_req_rw, m0_req_burst, m0_req_beats, m0_req_addr} =
                {cfgs[tbl[k].c0].rw, cfgs[tbl[k].c0].burst, cfgs[tbl[k].c0].beats, cfgs[tbl[k].c0].addr};
            {m1_req_rw, m1_req_burst, m1_req_beats, m1_req_addr} =
                {cfgs[tbl[k].c1].rw, cfgs[tbl[k].c1].burst, cfgs[tbl[k].c1].beats, cfgs[tbl[k].c1].addr};
            {m1_req_valid, m0_req_valid}     = tbl[k].rv;
            {m1_write_valid, m0_write_valid} = tbl[k].wv;
            {m1_read_ready, m0_read_ready}   = tbl[k].rr;
            m0_write_data = tbl[k].wd0; m1_write_data = tbl[k].wd1;
            req_ready = tbl[k].rq_rdy; write_ready = tbl[k].wr_rdy;
            read_valid = tbl[k].rd_vld; read_data = tbl[k].rd;
            #1;
            check(tbl[k].nm,
                  {req_valid, req_addr, m1_req_ready, m0_req_ready, write_valid, write_data,
                   m1_write_ready, m0_write_ready, read_ready, m1_read_valid, m0_read_valid,
                   m0_read_data, m1_read_data},
                  {tbl[k].e_reqv, tbl[k].e_addr, tbl[k].e_reqrdy, tbl[k].e_wv, tbl[k].e_wd,
                   tbl[k].e_wrdy, tbl[k].e_rrdy, tbl[k].e_rv, tbl[k].e_rd0, tbl[k].e_rd1});
        end
        check("tbl_wr_count", 128'(wr_log.size() - base), 128'd7);
        check("tbl_wr_order", log_pack(base),
              {16'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0BEE});

        // m0 single write held off by write_ready=0 for 25 cycles.
        base = wr_log.size();
        {m0_req_rw, m0_req_burst, m0_req_beats, m0_req_addr} = {1'b1, 1'b0, 14'd0, 32'h0};
        {m0_write_valid, m1_write_valid, m1_req_valid, m0_read_ready, m1_read_ready} = '0;
        read_valid = 1'b0; read_data = '0;
        @(negedge clk);
        m0_req_valid = 1'b1; req_ready = 1'b1; write_ready = 1'b0;
        #1 check("t1_arb_latency", 128'(req_valid), 128'd0);
        @(negedge clk); #1;
        check("t1_req_fwd", {req_valid, req_rw, req_burst, req_addr, req_beats, m0_req_ready, m1_req_ready},
              {1'b1, 1'b1, 1'b0, 32'h0, 14'd0, 1'b1, 1'b0});
        @(negedge clk);
        m0_req_valid = 1'b0; m0_write_valid = 1'b1; m0_write_data = 16'h000F;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (!(write_valid === 1'b1 && write_data === 16'h000F &&
                  m0_write_ready === 1'b0 && m1_write_ready === 1'b0)) bad++;
            @(negedge clk);
        end
        check("t1_stall_hold", 128'(bad), 128'd0);
        write_ready = 1'b1;
        #1 check("t1_beat", {write_valid, write_data, write_strb, m0_write_ready, m1_write_ready},
                 {1'b1, 16'h000F, 2'b11, 1'b1, 1'b0});
        @(negedge clk);
        #1 check("t1_back_idle", all_out(), '0);
        m0_write_valid = 1'b0;
        check("t1_one_beat", {112'(wr_log.size() - base), log_pack(base)[15:0]}, {112'd1, 16'h000F});

        // m0 back-to-back single reads while m1 waits: grants m0, m1, m0.
        {m0_req_rw, m0_req_burst, m0_req_beats, m0_req_addr} = {1'b0, 1'b0, 14'd0, 32'h40};
        {m1_req_rw, m1_req_burst, m1_req_beats, m1_req_addr} = {1'b0, 1'b0, 14'd0, 32'h80};
        @(negedge clk);
        m0_req_valid = 1'b1; m0_read_ready = 1'b1; m1_read_ready = 1'b1;
        req_ready = 1'b1; write_ready = 1'b0; read_valid = 1'b1; read_data = 16'h00D0;
        @(negedge clk);
        m1_req_valid = 1'b1;
        #1 check("t4_gnt1_m0", {req_valid, req_addr, m0_req_ready, m1_req_ready}, {1'b1, 32'h40, 1'b1, 1'b0});
        @(negedge clk); #1;
        check("t4_rd_m0", {m0_read_valid, m0_read_data, m1_read_valid, m1_read_data, read_ready},
              {1'b1, 16'h00D0, 1'b0, 16'h0, 1'b1});
        @(negedge clk); #1 check("t4_gap1", 128'(req_valid), 128'd0);
        @(negedge clk); #1;
        check("t4_gnt2_m1", {req_valid, req_addr, m0_req_ready, m1_req_ready}, {1'b1, 32'h80, 1'b0, 1'b1});
        @(negedge clk);
        m1_req_valid = 1'b0; read_data = 16'h00D1;
        #1 check("t4_rd_m1", {m1_read_valid, m1_read_data, m0_read_valid, m0_read_data},
                 {1'b1, 16'h00D1, 1'b0, 16'h0});
        @(negedge clk); #1 check("t4_gap2", 128'(req_valid), 128'd0);
        @(negedge clk); #1;
        check("t4_gnt3_m0", {req_valid, req_addr, m0_req_ready, m1_req_ready}, {1'b1, 32'h40, 1'b1, 1'b0});
        @(negedge clk);
        m0_req_valid = 1'b0; read_data = 16'h00D2;
        #1 check("t4_rd_m0_2", {m0_read_valid, m0_read_data}, {1'b1, 16'h00D2});
        @(negedge clk);
        read_valid = 1'b0;
        #1 check("t4_idle", all_out(), '0);

        // Reset during beat 2 of an 8-beat m1 write, then prio must be back on m0.
        {m1_req_rw, m1_req_burst, m1_req_beats, m1_req_addr} = {1'b1, 1'b1, 14'd8, 32'h500};
        write_ready = 1'b1;
        @(negedge clk); m1_req_valid = 1'b1;
        @(negedge clk);
        #1 check("t5_req_m1", {req_valid, req_beats, req_burst, m1_req_ready}, {1'b1, 14'd8, 1'b1, 1'b1});
        @(negedge clk);
        m1_req_valid = 1'b0; m1_write_valid = 1'b1; m1_write_data = 16'h0101;
        @(negedge clk);
        m1_write_data = 16'h0102; rst = 1'b1;
        #1 check("t5_beat2", {write_valid, write_data, m1_write_ready}, {1'b1, 16'h0102, 1'b1});
        @(negedge clk);
        rst = 1'b0; read_valid = 1'b1;
        #1 check("t5_after_rst", all_out(), '0);
        base = wr_log.size();
        @(negedge clk);
        m1_write_valid = 1'b0; read_valid = 1'b0;
        {m0_req_rw, m0_req_burst, m0_req_beats, m0_req_addr} = {1'b1, 1'b0, 14'd0, 32'hB0};
        {m1_req_rw, m1_req_burst, m1_req_beats, m1_req_addr} = {1'b1, 1'b0, 14'd0, 32'hC0};
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        @(negedge clk); #1;
        check("t5_prio_m0", {req_valid, req_addr, m0_req_ready, m1_req_ready}, {1'b1, 32'hB0, 1'b1, 1'b0});
        @(negedge clk);
        m0_req_valid = 1'b0; m0_write_valid = 1'b1; m0_write_data = 16'h000B;
        #1 check("t5_wr_m0", {write_valid, write_data, m0_write_ready}, {1'b1, 16'h000B, 1'b1});
        @(negedge clk);
        m0_write_valid = 1'b0;
        #1 check("t5_gap", 128'(req_valid), 128'd0);
        @(negedge clk); #1;
        check("t5_gnt_m1", {req_valid, req_addr, m0_req_ready, m1_req_ready}, {1'b1, 32'hC0, 1'b0, 1'b1});
        @(negedge clk);
        m1_req_valid = 1'b0; m1_write_valid = 1'b1; m1_write_data = 16'h000C;
        #1 check("t5_wr_m1", {write_valid, write_data, write_strb, m1_write_ready, m0_write_ready},
                 {1'b1, 16'h000C, 2'b10, 1'b1, 1'b0});
        @(negedge clk);
        m1_write_valid = 1'b0;
        #1 check("t5_final_idle", all_out(), '0);
        check("t5_wr_log", {96'(wr_log.size() - base), log_pack(base)[31:0]}, {96'd2, 16'h000B, 16'h000C});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mam_mem_arbiter.md
Name: mam_mem_arbiter

Overview:
- Shares one memory port, in the MAM request/write/read protocol, between two MAM-style masters (m0, m1), e.g. two osd_mam instances or osd_mam plus a CPU-side bridge.
- Round-robin grant; the grant is locked for a whole transaction (request plus all data beats).
- Sits between the masters and the memory controller.
- Purely a sequencer/multiplexer: no buffering of data beats.

Parameters:
DATA_WIDTH, 16, width of write/read data words
ADDR_WIDTH, 32, width of request address

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-high
mN_req_valid  in  1  master N request valid (N=0,1)
mN_req_ready  out  1  request accepted by memory for master N
mN_req_rw  in  1  1=write, 0=read
mN_req_addr  in  ADDR_WIDTH  start address
mN_req_burst  in  1  1=burst of mN_req_beats words, 0=single word
mN_req_beats  in  14  burst length in words
mN_write_valid  in  1  write beat valid
mN_write_data  in  DATA_WIDTH  write beat data
mN_write_strb  in  DATA_WIDTH/8  byte strobes
mN_write_ready  out  1  write beat accepted
mN_read_valid  out  1  read beat valid
mN_read_data  out  DATA_WIDTH  read beat data
mN_read_ready  in  1  master accepts read beat
req_valid, req_rw, req_addr, req_burst, req_beats  out  1/1/ADDR_WIDTH/1/14  request to memory
req_ready  in  1  memory accepts request
write_valid, write_data, write_strb  out  1/DATA_WIDTH/DATA_WIDTH/8  write beat to memory
write_ready  in  1  memory accepts write beat
read_valid, read_data  in  1/DATA_WIDTH  read beat from memory
read_ready  out  1  read beat accepted

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst).
- Reset values:
  - state=IDLE; prio=m0.
  - beat counter=0.
  - All outputs 0: mN_req_ready, mN_write_ready, mN_read_valid, mN_read_data, req_*, write_*, read_ready.
- FSM states: IDLE, REQ, DATA.
- IDLE:
  - Sample mN_req_valid.
  - Only one valid: grant it.
  - Both valid: grant prio.
  - Neither valid: stay.
  - On a grant, register gnt and go to REQ next cycle. This gives 1 cycle of arbitration latency.
- REQ:
  - req_* = granted master's request fields, combinational.
  - Granted mN_req_ready = req_ready.
  - On req_valid && req_ready, latch rw and the beat count, then go to DATA.
  - Beat count = req_burst ? req_beats : 1. A burst with beats=0 is treated as 1.
  - Granted master must hold req_valid until the handshake. The arbiter does not drop the grant.
- DATA, write (rw=1):
  - write_valid/data/strb = granted master's signals.
  - Granted mN_write_ready = write_ready.
  - Each write_valid && write_ready decrements the counter.
- DATA, read (rw=0):
  - Granted mN_read_valid/read_data = read_valid/read_data.
  - read_ready = granted mN_read_ready.
  - Each read_valid && read_ready decrements the counter.
- Last-beat handshake (counter==1):
  - Go to IDLE next cycle.
  - prio <= the non-granted master.
  - Minimum gap between two transactions is 1 IDLE cycle.
- Non-granted master, at all times:
  - req_ready=0, write_ready=0, read_valid=0, read_data=0.
  - Its requests stay pending; they are never dropped.
- Memory side outside the matching phase:
  - req_valid=0 outside REQ.
  - write_valid=0 outside DATA-write.
  - read_ready=0 outside DATA-read.
- Memory read_valid arriving outside DATA-read is not acknowledged (read_ready=0).
- Request fields are driven only in REQ. Otherwise req_addr/req_beats/req_rw/req_burst=0.
- rst asserted mid-transaction:
  - Immediate return to IDLE, counter=0, prio=m0.
  - Partial burst abandoned. The memory controller must be reset together with the arbiter.
- Counter is 14 bits and never wraps; max burst 16383 beats.

Test Plan:
1. m0 single write (rw=1, addr=0x0, burst=0, data=0x000F) with write_ready held 0 for 25 cycles -> req forwarded 1 cycle after m0_req_valid; write_valid held with data 0x000F until write_ready=1; one write beat; m1 sees no ready.
2. m0 and m1 raise req_valid in the same cycle (both burst writes, beats=3) -> m0 granted first, data 0x0001..0x0003; then exactly 1 IDLE cycle; m1 granted, data 0x0004..0x0006; memory sees 6 write beats in order.
3. m1 burst read, beats=4, memory returns 0xA0..0xA3, m1_read_ready toggled 0/1 each cycle -> read_ready mirrors m1_read_ready; m1 receives exactly 4 beats in order; m0_read_valid stays 0.
4. m0 issues back-to-back single reads while m1 holds req_valid -> grants alternate m0, m1, m0; m1 waits at most one m0 transaction.
5. rst pulsed during beat 2 of an 8-beat write -> next cycle state=IDLE, all outputs 0; a subsequent m1 single write (0x000C) completes normally with prio reset to m0.
6. Burst with beats=0 -> treated as single beat; arbiter returns to IDLE after one data handshake.
